// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the hazard controller and its multi-cycle tracking pipe.
package hazard_ctrl_pkg;

  localparam int MC_LAT_DEF       = 4;
  localparam int WIDTH_SOURCE_DEF = 5;

  typedef enum logic {
    CLS_INT = 1'b0,
    CLS_FP  = 1'b1
  } reg_cls_e;

  // One slot of the in-flight tracking pipe
  typedef struct packed {
    logic                        valid;
    logic [WIDTH_SOURCE_DEF-1:0] rd;
  } mc_entry_t;

  function automatic reg_cls_e cls_of(input logic is_fp);
    return is_fp ? CLS_FP : CLS_INT;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_track_pipe.sv
// mc_track_pipe: shift pipeline of in-flight multi-cycle FP ops; yields pending map and writeback.
module mc_track_pipe
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT       = MC_LAT_DEF,
  parameter int WIDTH_SOURCE = WIDTH_SOURCE_DEF
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       issue,
  input  logic [WIDTH_SOURCE-1:0]    issue_rd,
  output logic [2**WIDTH_SOURCE-1:0] pending,
  output logic                       mc_wb,
  output logic [WIDTH_SOURCE-1:0]    mc_wb_rd,
  output logic                       mc_busy
);

  mc_entry_t stage [MC_LAT];

  // The last stage writes back this cycle and simply shifts out on the next edge
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < MC_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0].valid <= issue;
      stage[0].rd    <= issue ? WIDTH_SOURCE_DEF'(issue_rd) : '0;
      for (int i = 1; i < MC_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // The writeback stage still counts as pending: there is no writeback-to-ID bypass
  always_comb begin
    pending = '0;
    mc_busy = 1'b0;
    for (int i = 0; i < MC_LAT; i++) begin
      if (stage[i].valid) begin
        pending[WIDTH_SOURCE'(stage[i].rd)] = 1'b1;
        mc_busy = 1'b1;
      end
    end
  end

  assign mc_wb    = stage[MC_LAT-1].valid;
  assign mc_wb_rd = stage[MC_LAT-1].valid ? WIDTH_SOURCE'(stage[MC_LAT-1].rd) : '0;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage load-use / multi-cycle RAW-WAW stalls and taken-branch flush.
// Defining HAZARD_PERF_CNT_EN adds the stall_cnt / flush_cnt performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT       = MC_LAT_DEF,
  parameter int WIDTH_SOURCE = WIDTH_SOURCE_DEF
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [WIDTH_SOURCE-1:0] IF_ID_rs1,
  input  logic [WIDTH_SOURCE-1:0] IF_ID_rs2,
  input  logic                    IF_ID_rs1_fp,
  input  logic                    IF_ID_rs2_fp,
  input  logic                    IF_ID_rs1_used,
  input  logic                    IF_ID_rs2_used,
  input  logic                    ID_EX_Mem_Rd,
  input  logic [WIDTH_SOURCE-1:0] ID_EX_rd,
  input  logic                    ID_EX_rd_fp,
  input  logic                    mc_issue,
  input  logic [WIDTH_SOURCE-1:0] mc_rd,
  input  logic                    branch_taken,
  output logic                    PC_Wr,
  output logic                    IF_ID_Wr,
  output logic                    ID_EX_bubble,
  output logic                    IF_ID_flush,
  output logic                    mc_wb,
  output logic [WIDTH_SOURCE-1:0] mc_wb_rd,
  output logic                    mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
`endif
);

  logic [2**WIDTH_SOURCE-1:0] pending;
  logic lu_haz, raw_haz, waw_haz, stall, issue_ok;
  logic rs1_lu, rs2_lu, ex_rd_is_x0;

  mc_track_pipe #(
    .MC_LAT       (MC_LAT),
    .WIDTH_SOURCE (WIDTH_SOURCE)
  ) u_pipe (
    .CLK      (CLK),
    .rst      (rst),
    .issue    (issue_ok),
    .issue_rd (mc_rd),
    .pending  (pending),
    .mc_wb    (mc_wb),
    .mc_wb_rd (mc_wb_rd),
    .mc_busy  (mc_busy)
  );

  // x0 is hard-wired so a load to it never blocks; f0 is a real register and does
  always_comb begin
    ex_rd_is_x0 = (cls_of(ID_EX_rd_fp) == CLS_INT) && (ID_EX_rd == '0);
    rs1_lu = IF_ID_rs1_used && (cls_of(IF_ID_rs1_fp) == cls_of(ID_EX_rd_fp))
             && (IF_ID_rs1 == ID_EX_rd);
    rs2_lu = IF_ID_rs2_used && (cls_of(IF_ID_rs2_fp) == cls_of(ID_EX_rd_fp))
             && (IF_ID_rs2 == ID_EX_rd);
    lu_haz  = ID_EX_Mem_Rd && !ex_rd_is_x0 && (rs1_lu || rs2_lu);
    raw_haz = (IF_ID_rs1_used && (cls_of(IF_ID_rs1_fp) == CLS_FP) && pending[IF_ID_rs1])
           || (IF_ID_rs2_used && (cls_of(IF_ID_rs2_fp) == CLS_FP) && pending[IF_ID_rs2]);
    waw_haz = mc_issue && pending[mc_rd];
    stall   = lu_haz || raw_haz || waw_haz;
  end

  // A taken branch squashes the ID instruction, so any stall it raised is moot
  always_comb begin
    PC_Wr        = !stall;
    IF_ID_Wr     = !stall;
    ID_EX_bubble = stall;
    IF_ID_flush  = 1'b0;
    issue_ok     = mc_issue && !stall;
    if (branch_taken) begin
      PC_Wr        = 1'b1;
      IF_ID_Wr     = 1'b1;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b1;
      issue_ok     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !branch_taken) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken)           flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus random traffic, checked by a
// scoreboard against an in-flight-list reference model (HAZARD_PERF_CNT_EN optional).
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int W   = 5;

  typedef struct {
    bit         rst;
    bit [W-1:0] rs1, rs2;
    bit         rs1_fp, rs2_fp, rs1_used, rs2_used;
    bit         ld;
    bit [W-1:0] ex_rd;
    bit         ex_rd_fp;
    bit         issue;
    bit [W-1:0] mc_rd;
    bit         br;
  } stim_t;

  typedef struct {
    bit [3:0]   haz;
    bit         wb;
    bit [W-1:0] wb_rd;
    bit         busy;
    bit [31:0]  scnt, fcnt;
  } exp_t;

  typedef struct {
    bit [W-1:0] rd;
    int         age;
  } flight_t;

  logic CLK = 1'b0;
  logic rst;
  logic [W-1:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, mc_rd;
  logic IF_ID_rs1_fp, IF_ID_rs2_fp, IF_ID_rs1_used, IF_ID_rs2_used;
  logic ID_EX_Mem_Rd, ID_EX_rd_fp, mc_issue, branch_taken;
  logic PC_Wr, IF_ID_Wr, ID_EX_bubble, IF_ID_flush, mc_wb, mc_busy;
  logic [W-1:0] mc_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MC_LAT(LAT), .WIDTH_SOURCE(W)) dut (
    .CLK(CLK), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_rs1_fp(IF_ID_rs1_fp), .IF_ID_rs2_fp(IF_ID_rs2_fp),
    .IF_ID_rs1_used(IF_ID_rs1_used), .IF_ID_rs2_used(IF_ID_rs2_used),
    .ID_EX_Mem_Rd(ID_EX_Mem_Rd), .ID_EX_rd(ID_EX_rd), .ID_EX_rd_fp(ID_EX_rd_fp),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .branch_taken(branch_taken),
    .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .mc_wb(mc_wb), .mc_wb_rd(mc_wb_rd), .mc_busy(mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  exp_t    sb[$];
  flight_t inflight[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  bit [31:0] m_scnt = 0, m_fcnt = 0;

  function automatic bit is_pending(input bit [W-1:0] r);
    foreach (inflight[i]) if (inflight[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Drive one ID-stage cycle, queue the expected response, then advance the model past the edge
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit lu, raw, waw, stall, acc;
    rst = s.rst;
    IF_ID_rs1 = s.rs1; IF_ID_rs2 = s.rs2;
    IF_ID_rs1_fp = s.rs1_fp; IF_ID_rs2_fp = s.rs2_fp;
    IF_ID_rs1_used = s.rs1_used; IF_ID_rs2_used = s.rs2_used;
    ID_EX_Mem_Rd = s.ld; ID_EX_rd = s.ex_rd; ID_EX_rd_fp = s.ex_rd_fp;
    mc_issue = s.issue; mc_rd = s.mc_rd; branch_taken = s.br;

    lu = s.ld && !(!s.ex_rd_fp && s.ex_rd == 0) &&
         ((s.rs1_used && s.rs1_fp == s.ex_rd_fp && s.rs1 == s.ex_rd) ||
          (s.rs2_used && s.rs2_fp == s.ex_rd_fp && s.rs2 == s.ex_rd));
    raw = (s.rs1_used && s.rs1_fp && is_pending(s.rs1)) ||
          (s.rs2_used && s.rs2_fp && is_pending(s.rs2));
    waw = s.issue && is_pending(s.mc_rd);
    stall = lu || raw || waw;
    acc = s.issue && !stall && !s.br;

    if (s.br) e.haz = 4'b1111;
    else      e.haz = {!stall, !stall, stall, 1'b0};
    e.wb = 0; e.wb_rd = 0;
    foreach (inflight[i]) if (inflight[i].age == LAT-1) begin
      e.wb = 1; e.wb_rd = inflight[i].rd;
    end
    e.busy = inflight.size() != 0;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);

    @(posedge CLK);
    if (s.rst) begin
      inflight.delete();
      m_scnt = 0; m_fcnt = 0;
    end else begin
      for (int i = inflight.size() - 1; i >= 0; i--) begin
        if (inflight[i].age == LAT-1) inflight.delete(i);
        else inflight[i].age++;
      end
      if (acc) inflight.push_back('{rd: s.mc_rd, age: 0});
      if (stall && !s.br) m_scnt++;
      if (s.br) m_fcnt++;
    end
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    bit [3:0] act;
    act = {PC_Wr, IF_ID_Wr, ID_EX_bubble, IF_ID_flush};
    n_checks++;
    if (act === e.haz) n_pass++;
    else $display("[TB] FAIL hazard_outputs t=%0t pc/ifid/bubble/flush got %b expected %b", $time, act, e.haz);
    n_checks++;
    if ({mc_wb, mc_wb_rd, mc_busy} === {e.wb, e.wb_rd, e.busy}) n_pass++;
    else $display("[TB] FAIL mc_writeback t=%0t wb/rd/busy got %b/%0d/%b expected %b/%0d/%b",
                  $time, mc_wb, mc_wb_rd, mc_busy, e.wb, e.wb_rd, e.busy);
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cnt === e.scnt && flush_cnt === e.fcnt) n_pass++;
    else $display("[TB] FAIL perf_counters t=%0t stall/flush got %0d/%0d expected %0d/%0d",
                  $time, stall_cnt, flush_cnt, e.scnt, e.fcnt);
`endif
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued entry per negedge
  always @(negedge CLK) begin
    if (sb.size() != 0) checkOutput(sb.pop_front());
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_rs1_fp = 0; IF_ID_rs2_fp = 0;
    IF_ID_rs1_used = 0; IF_ID_rs2_used = 0; ID_EX_Mem_Rd = 0; ID_EX_rd = '0;
    ID_EX_rd_fp = 0; mc_issue = 0; mc_rd = '0; branch_taken = 0;
    repeat (2) @(posedge CLK);
    #1;

    s = idle(); s.rst = 1; applyStimulus(s);
    applyStimulus(idle());

    // load-use on x5, then the same with x0
    s = idle(); s.ld = 1; s.ex_rd = 5; s.rs2 = 5; s.rs2_used = 1; applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.ld = 1; s.ex_rd = 0; s.rs2 = 0; s.rs2_used = 1; applyStimulus(s);

    // f3 RAW until writeback, then integer x3 read
    s = idle(); s.issue = 1; s.mc_rd = 3; applyStimulus(s);
    s = idle(); s.rs1 = 3; s.rs1_fp = 1; s.rs1_used = 1;
    repeat (LAT + 1) applyStimulus(s);
    s.rs1_fp = 0; applyStimulus(s);

    // four back-to-back issues
    for (int r = 1; r <= 4; r++) begin
      s = idle(); s.issue = 1; s.mc_rd = W'(r); applyStimulus(s);
    end
    repeat (LAT + 1) applyStimulus(idle());

    // WAW on f7
    s = idle(); s.issue = 1; s.mc_rd = 7; repeat (LAT + 2) applyStimulus(s);
    repeat (LAT + 1) applyStimulus(idle());

    // branch overrides load-use and blocks the issue; in-flight op still drains
    s = idle(); s.issue = 1; s.mc_rd = 2; applyStimulus(s);
    s = idle(); s.br = 1; s.ld = 1; s.ex_rd = 9; s.rs1 = 9; s.rs1_used = 1;
    s.issue = 1; s.mc_rd = 5; applyStimulus(s);
    repeat (LAT + 1) applyStimulus(idle());

    // reset with two ops in flight
    s = idle(); s.issue = 1; s.mc_rd = 10; applyStimulus(s);
    s.mc_rd = 11; applyStimulus(s);
    s = idle(); s.rst = 1; applyStimulus(s);
    repeat (LAT + 1) applyStimulus(idle());

    // random traffic on a small register range to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 63) == 0);
      s.rs1      = W'($urandom_range(0, 7));
      s.rs2      = W'($urandom_range(0, 7));
      s.rs1_fp   = 1'($urandom_range(0, 1));
      s.rs2_fp   = 1'($urandom_range(0, 1));
      s.rs1_used = 1'($urandom_range(0, 1));
      s.rs2_used = 1'($urandom_range(0, 1));
      s.ld       = ($urandom_range(0, 2) == 0);
      s.ex_rd    = W'($urandom_range(0, 7));
      s.ex_rd_fp = 1'($urandom_range(0, 1));
      s.issue    = 1'($urandom_range(0, 1));
      s.mc_rd    = W'($urandom_range(0, 7));
      s.br       = ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end

    repeat (2) @(negedge CLK);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain leftover %0d expected 0", sb.size());

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
